// File: rtl/fir_coeff_loader.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : fir_coeff_loader                                                 |
// | Desc    : Collects a host coefficient set into a buffer, then replays it   |
// |           as one contiguous coefficient-update burst to the FIR controller.|
// |           Define COEFF_CHECKSUM_EN to require a trailing checksum word.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fir_coeff_loader #(
    parameter int MAX_COEFF = 40,
    parameter int DATA_W    = 16
) (
    input  logic              iClk12M,
    input  logic              iRsn,
    input  logic              iLoadReq,
    input  logic [5:0]        iLoadNum,
    input  logic              iCoeffValid,
    input  logic [DATA_W-1:0] iCoeffData,
    output logic              oCoeffReady,
    input  logic              iFirBusy,
    output logic              oCoeffUpdateFlag,
    output logic [5:0]        oAddrRam,
    output logic [DATA_W-1:0] oWrDtRam,
    output logic [5:0]        oNumOfCoeff,
    output logic              oBusy,
    output logic              oLoadDone,
    output logic              oLoadErr
);

    localparam logic [5:0] c_MAX_N = 6'(MAX_COEFF);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
`ifdef COEFF_CHECKSUM_EN
        CHECK   = 3'd2,
`endif
        WAITFIR = 3'd3,
        BURST   = 3'd4,
        GAP     = 3'd5
    } state_t;

    state_t            r_state,      w_stateNxt;
    logic [5:0]        r_wrPtr,      w_wrPtrNxt;
    logic [5:0]        r_rdPtr,      w_rdPtrNxt;
    logic [5:0]        r_loadNum,    w_loadNumNxt;
    logic              r_gapCnt,     w_gapCntNxt;
    logic              r_flag,       w_flagNxt;
    logic [5:0]        r_addr,       w_addrNxt;
    logic [DATA_W-1:0] r_wrDt,       w_wrDtNxt;
    logic [5:0]        r_numOfCoeff, w_numNxt;
    logic              r_loadDone,   w_doneNxt;
    logic              r_loadErr,    w_errNxt;
`ifdef COEFF_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum,        w_sumNxt;
    logic [DATA_W-1:0] r_chkWord,    w_chkNxt;
`endif

    logic [DATA_W-1:0] r_coeffBuf [MAX_COEFF];
    logic              w_accept;
    logic              w_bufWe;
    logic [DATA_W-1:0] w_rdData;

    assign w_accept = (r_state == COLLECT) && iCoeffValid;
    // Words beyond index N-1 in COLLECT can only be the checksum word
    assign w_bufWe  = w_accept && (r_wrPtr < r_loadNum);
    assign w_rdData = r_coeffBuf[r_rdPtr];

    always_comb begin
        w_stateNxt   = r_state;
        w_wrPtrNxt   = r_wrPtr;
        w_rdPtrNxt   = r_rdPtr;
        w_loadNumNxt = r_loadNum;
        w_gapCntNxt  = r_gapCnt;
        w_flagNxt    = 1'b0;
        w_addrNxt    = '0;
        w_wrDtNxt    = '0;
        w_numNxt     = r_numOfCoeff;
        w_doneNxt    = 1'b0;
        w_errNxt     = 1'b0;
`ifdef COEFF_CHECKSUM_EN
        w_sumNxt     = r_sum;
        w_chkNxt     = r_chkWord;
`endif
        case (r_state)
            IDLE: begin
                if (iLoadReq) begin
                    if ((iLoadNum != 6'd0) && (iLoadNum <= c_MAX_N)) begin
                        w_loadNumNxt = iLoadNum;
                        w_wrPtrNxt   = '0;
                        w_rdPtrNxt   = '0;
`ifdef COEFF_CHECKSUM_EN
                        w_sumNxt     = '0;
`endif
                        w_stateNxt   = COLLECT;
                    end else begin
                        w_errNxt = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (w_bufWe) begin
                    w_wrPtrNxt = r_wrPtr + 6'd1;
`ifdef COEFF_CHECKSUM_EN
                    w_sumNxt   = r_sum + iCoeffData;
`else
                    if (r_wrPtr == (r_loadNum - 6'd1)) begin
                        w_stateNxt = WAITFIR;
                    end
`endif
                end
`ifdef COEFF_CHECKSUM_EN
                else if (w_accept) begin
                    w_chkNxt   = iCoeffData;
                    w_stateNxt = CHECK;
                end
`endif
            end
`ifdef COEFF_CHECKSUM_EN
            CHECK: begin
                if (r_sum == r_chkWord) begin
                    w_stateNxt = WAITFIR;
                end else begin
                    w_errNxt   = 1'b1;
                    w_stateNxt = IDLE;
                end
            end
`endif
            WAITFIR: begin
                if (!iFirBusy) begin
                    w_stateNxt = BURST;
                    w_flagNxt  = 1'b1;
                    w_addrNxt  = r_rdPtr;
                    w_wrDtNxt  = w_rdData;
                    w_rdPtrNxt = r_rdPtr + 6'd1;
                    w_numNxt   = r_loadNum - 6'd1;
                end
            end
            BURST: begin
                if (r_rdPtr == r_loadNum) begin
                    w_stateNxt  = GAP;
                    w_gapCntNxt = 1'b0;
                end else begin
                    w_flagNxt  = 1'b1;
                    w_addrNxt  = r_rdPtr;
                    w_wrDtNxt  = w_rdData;
                    w_rdPtrNxt = r_rdPtr + 6'd1;
                end
            end
            GAP: begin
                if (!r_gapCnt) begin
                    w_gapCntNxt = 1'b1;
                    w_doneNxt   = 1'b1;
                end else begin
                    w_stateNxt = IDLE;
                end
            end
            default: w_stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_state      <= IDLE;
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_loadNum    <= '0;
            r_gapCnt     <= 1'b0;
            r_flag       <= 1'b0;
            r_addr       <= '0;
            r_wrDt       <= '0;
            r_numOfCoeff <= '0;
            r_loadDone   <= 1'b0;
            r_loadErr    <= 1'b0;
`ifdef COEFF_CHECKSUM_EN
            r_sum        <= '0;
            r_chkWord    <= '0;
`endif
        end else begin
            r_state      <= w_stateNxt;
            r_wrPtr      <= w_wrPtrNxt;
            r_rdPtr      <= w_rdPtrNxt;
            r_loadNum    <= w_loadNumNxt;
            r_gapCnt     <= w_gapCntNxt;
            r_flag       <= w_flagNxt;
            r_addr       <= w_addrNxt;
            r_wrDt       <= w_wrDtNxt;
            r_numOfCoeff <= w_numNxt;
            r_loadDone   <= w_doneNxt;
            r_loadErr    <= w_errNxt;
`ifdef COEFF_CHECKSUM_EN
            r_sum        <= w_sumNxt;
            r_chkWord    <= w_chkNxt;
`endif
        end
    end

    // Buffer deliberately has no reset; only indices below N are ever replayed
    always_ff @(posedge iClk12M) begin
        if (w_bufWe) begin
            r_coeffBuf[r_wrPtr] <= iCoeffData;
        end
    end

    assign oCoeffReady      = (r_state == COLLECT);
    assign oBusy            = (r_state != IDLE);
    assign oCoeffUpdateFlag = r_flag;
    assign oAddrRam         = r_addr;
    assign oWrDtRam         = r_wrDt;
    assign oNumOfCoeff      = r_numOfCoeff;
    assign oLoadDone        = r_loadDone;
    assign oLoadErr         = r_loadErr;

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : tb_fir_coeff_loader                                              |
// | Desc    : Randomized self-checking bench for fir_coeff_loader against a    |
// |           queue-based model of the expected burst and its timing.          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_fir_coeff_loader;

`ifdef COEFF_CHECKSUM_EN
    localparam int c_EXTRA = 1;
`else
    localparam int c_EXTRA = 0;
`endif

    logic        iClk12M = 1'b0;
    logic        iRsn = 1'b0;
    logic        iLoadReq = 1'b0;
    logic [5:0]  iLoadNum = '0;
    logic        iCoeffValid = 1'b0;
    logic [15:0] iCoeffData = '0;
    logic        oCoeffReady;
    logic        iFirBusy = 1'b0;
    logic        oCoeffUpdateFlag;
    logic [5:0]  oAddrRam;
    logic [15:0] oWrDtRam;
    logic [5:0]  oNumOfCoeff;
    logic        oBusy;
    logic        oLoadDone;
    logic        oLoadErr;

    fir_coeff_loader #(.MAX_COEFF(40), .DATA_W(16)) dut (
        .iClk12M          (iClk12M),
        .iRsn             (iRsn),
        .iLoadReq         (iLoadReq),
        .iLoadNum         (iLoadNum),
        .iCoeffValid      (iCoeffValid),
        .iCoeffData       (iCoeffData),
        .oCoeffReady      (oCoeffReady),
        .iFirBusy         (iFirBusy),
        .oCoeffUpdateFlag (oCoeffUpdateFlag),
        .oAddrRam         (oAddrRam),
        .oWrDtRam         (oWrDtRam),
        .oNumOfCoeff      (oNumOfCoeff),
        .oBusy            (oBusy),
        .oLoadDone        (oLoadDone),
        .oLoadErr         (oLoadErr)
    );

    always #41 iClk12M = ~iClk12M;

    int cyc = 0;
    always @(posedge iClk12M) cyc <= cyc + 1;

    int          nChecks = 0;
    int          nErrors = 0;
    int          expNum  = 0;
    logic [15:0] model [$];

    task automatic checkVal(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic fillRandom(input int n);
        model.delete();
        for (int k = 0; k < n; k++) model.push_back(16'($urandom));
    endtask

    // Drives one load of the words in model and checks the replayed burst.
    task automatic runLoad(input int n, input int stallPct, input int busyHold,
                           input int sumAdj, input int rstBeat);
        int          t = 0;
        int          sent = 0;
        int          total;
        int          flagStart;
        int          beats = 0;
        int          doneAt = -1;
        int          errSeen = 0;
        int          badSum;
        logic [15:0] sum = '0;

        total  = n + c_EXTRA;
        badSum = (c_EXTRA != 0 && sumAdj != 0) ? 1 : 0;

        @(negedge iClk12M);
        iLoadReq = 1'b1;
        iLoadNum = 6'(n);
        iFirBusy = (busyHold > 0);
        @(negedge iClk12M);
        iLoadReq = 1'b0;
        checkVal("busyCollect", int'(oBusy), 1);
        checkVal("readyCollect", int'(oCoeffReady), 1);

        for (int g = 0; sent < total && g < 4000; g++) begin
            if (int'($urandom_range(99)) < stallPct) begin
                iCoeffValid = 1'b0;
            end else begin
                iCoeffValid = 1'b1;
                if (sent < n) iCoeffData = model[sent];
                else          iCoeffData = 16'(sum + 16'(sumAdj));
            end
            if (iCoeffValid && oCoeffReady) begin
                if (sent < n) sum = 16'(sum + model[sent]);
                sent++;
                t = cyc;
            end
            @(negedge iClk12M);
        end
        iCoeffValid = 1'b0;
        checkVal("wordsSent", sent, total);

        if (busyHold > 0) begin
            for (int g = 0; cyc < t + c_EXTRA + busyHold && g < 200; g++) @(negedge iClk12M);
            iFirBusy  = 1'b0;
            flagStart = cyc + 1;
        end else begin
            flagStart = t + 2 + c_EXTRA;
        end

        for (int g = 0; g < n + 40; g++) begin
            @(negedge iClk12M);
            if (oCoeffUpdateFlag) begin
                if (beats < n) begin
                    checkVal("beatCycle", cyc, flagStart + beats);
                    checkVal("beatAddr", int'(oAddrRam), beats);
                    checkVal("beatData", int'(oWrDtRam), int'(model[beats]));
                end
                if (beats == rstBeat) begin
                    iRsn = 1'b0;
                    #1;
                    checkVal("rstFlag", int'(oCoeffUpdateFlag), 0);
                    checkVal("rstOuts", int'({oAddrRam, oWrDtRam, oNumOfCoeff, oBusy,
                                              oCoeffReady, oLoadDone, oLoadErr}), 0);
                    expNum = 0;
                    @(negedge iClk12M);
                    iRsn = 1'b1;
                    return;
                end
                beats++;
            end
            if (oLoadDone) doneAt = cyc;
            if (oLoadErr)  errSeen = 1;
            if (doneAt >= 0 || errSeen != 0) break;
        end

        checkVal("beatCount", beats, badSum ? 0 : n);
        checkVal("doneCycle", doneAt, badSum ? -1 : flagStart + n + 1);
        checkVal("errPulse", errSeen, badSum);
        if (badSum == 0) expNum = n - 1;
        checkVal("numOfCoeff", int'(oNumOfCoeff), expNum);
        @(negedge iClk12M);
        checkVal("idleAfter", int'(oBusy), 0);
    endtask

    task automatic badReq(input int n);
        int bad = 0;
        @(negedge iClk12M);
        iLoadReq = 1'b1;
        iLoadNum = 6'(n);
        @(negedge iClk12M);
        iLoadReq = 1'b0;
        checkVal("rejectErr", int'(oLoadErr), 1);
        for (int g = 0; g < 6; g++) begin
            @(negedge iClk12M);
            if (oCoeffUpdateFlag || oCoeffReady || oLoadErr || oBusy) bad++;
        end
        checkVal("rejectQuiet", bad, 0);
        checkVal("rejectNum", int'(oNumOfCoeff), expNum);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge iClk12M);
        checkVal("resetFlag", int'(oCoeffUpdateFlag), 0);
        checkVal("resetOuts", int'({oAddrRam, oWrDtRam, oNumOfCoeff, oBusy,
                                    oCoeffReady, oLoadDone, oLoadErr}), 0);
        iRsn = 1'b1;
        @(negedge iClk12M);
        checkVal("idleBusy", int'(oBusy), 0);

        model = '{16'h0011, 16'h0022, 16'h0033};
        runLoad(3, 0, 0, 0, -1);

        model.delete();
        for (int k = 0; k < 40; k++) model.push_back(16'(16'h1000 + k));
        runLoad(40, 40, 0, 0, -1);

        badReq(0);
        badReq(41);
        badReq(int'($urandom_range(63, 42)));

        fillRandom(5);
        runLoad(5, 20, 20, 0, -1);

        for (int i = 0; i < 6; i++) begin
            n = int'($urandom_range(1, 40));
            fillRandom(n);
            runLoad(n, int'($urandom_range(0, 60)),
                    ($urandom_range(1) != 0) ? int'($urandom_range(1, 6)) : 0, 0, -1);
        end

        fillRandom(10);
        runLoad(10, 0, 0, 0, 4);
        fillRandom(4);
        runLoad(4, 10, 0, 0, -1);

`ifdef COEFF_CHECKSUM_EN
        model = '{16'h8000, 16'h8001};
        runLoad(2, 0, 0, 0, -1);
        fillRandom(7);
        runLoad(7, 0, 0, 0, -1);
        model = '{16'h8000, 16'h8001};
        runLoad(2, 0, 0, 1, -1);
`endif

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
